// File: rtl/card_dealer_if.sv
// Request/result bundle between the round controller and the card dealer.
// The controller side is the master; the dealer is the slave.
interface card_dealer_if;
  logic       new_hand;
  logic       deal_req;
  logic [1:0] deal_count;
  logic [5:0] rng_in;
  logic [5:0] card;
  logic       card_valid;
  logic [5:0] cards_dealt;
  logic       busy;
  logic       done;
  logic       err_empty;

  modport master (
    output new_hand, deal_req, deal_count, rng_in,
    input  card, card_valid, cards_dealt, busy, done, err_empty
  );

  modport slave (
    input  new_hand, deal_req, deal_count, rng_in,
    output card, card_valid, cards_dealt, busy, done, err_empty
  );
endinterface

// File: rtl/card_dealer.sv
// Deals unique cards from a DECK_SIZE deck using PRNG draws, falling back to
// a linear bitmap scan after MAX_TRIES consecutive rejected draws.
module card_dealer #(
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned MAX_TRIES = 255
) (
  input logic          clk,
  input logic          reset_d,
  card_dealer_if.slave bus
);
  localparam int unsigned CW   = 6;
  localparam int unsigned TW   = 8;
  localparam int unsigned MAPW = 1 << CW;
  localparam logic [CW-1:0] DECK_CODE = CW'(DECK_SIZE);
  localparam logic [TW-1:0] TRY_LIMIT = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_CHECK, S_SCAN, S_EMIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Bitmap is padded to the full code space so any 6-bit draw indexes safely.
  logic [MAPW-1:0] used, used_nxt;
  logic [CW-1:0]   cand, cand_nxt;
  logic [CW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   card_q, card_nxt;
  logic [CW-1:0]   dealt_q, dealt_nxt;
  logic [TW-1:0]   tries, tries_nxt;
  logic [1:0]      remaining, remaining_nxt;
  logic            valid_q, valid_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            err_q, err_nxt;

  logic            deck_full;
  logic            hit;
  logic            scan_free;
  logic [TW-1:0]   tries_inc;
  logic            emit;
  logic [CW-1:0]   pick;

  assign deck_full = (dealt_q == DECK_CODE);
  assign hit       = (cand < DECK_CODE) && !used[cand];
  assign scan_free = !used[ptr];
  assign tries_inc = tries + TW'(1);

  assign bus.card        = card_q;
  assign bus.card_valid  = valid_q;
  assign bus.cards_dealt = dealt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_empty   = err_q;

  // State register
  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; new_hand overrides everything
  always_comb begin
    state_nxt = state;
    if (bus.new_hand) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.deal_req)
                   state_nxt = (bus.deal_count != 2'd0) ? S_DRAW : S_DONE;
        S_DRAW:  state_nxt = deck_full ? S_DONE : S_CHECK;
        S_CHECK: if (hit)                         state_nxt = S_EMIT;
                 else if (tries_inc == TRY_LIMIT) state_nxt = S_SCAN;
                 else                             state_nxt = S_DRAW;
        S_SCAN:  if (scan_free) state_nxt = S_EMIT;
        S_EMIT:  state_nxt = (remaining == 2'd0) ? S_DONE : S_DRAW;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    used_nxt      = used;
    cand_nxt      = cand;
    ptr_nxt       = ptr;
    tries_nxt     = tries;
    remaining_nxt = remaining;
    card_nxt      = card_q;
    dealt_nxt     = dealt_q;
    valid_nxt     = 1'b0;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    err_nxt       = err_q;
    emit          = 1'b0;
    pick          = cand;
    if (bus.new_hand) begin
      used_nxt      = '0;
      ptr_nxt       = '0;
      tries_nxt     = '0;
      remaining_nxt = '0;
      dealt_nxt     = '0;
      busy_nxt      = 1'b0;
      err_nxt       = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.deal_req) begin
          if (bus.deal_count != 2'd0) begin
            remaining_nxt = bus.deal_count;
            busy_nxt      = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
        S_DRAW: if (deck_full) begin
          err_nxt  = 1'b1;
          done_nxt = 1'b1;
        end else begin
          cand_nxt = bus.rng_in;
        end
        S_CHECK: if (hit) begin
          emit = 1'b1;
        end else if (tries_inc == TRY_LIMIT) begin
          tries_nxt = '0;
          ptr_nxt   = '0;
        end else begin
          tries_nxt = tries_inc;
        end
        S_SCAN: if (scan_free) begin
          emit = 1'b1;
          pick = ptr;
        end else begin
          ptr_nxt = ptr + CW'(1);
        end
        S_EMIT: if (remaining == 2'd0) done_nxt = 1'b1;
        S_DONE: busy_nxt = 1'b0;
        default: ;
      endcase
      // The card is presented in the EMIT cycle, so it is loaded on entry
      if (emit) begin
        used_nxt[pick] = 1'b1;
        cand_nxt       = pick;
        card_nxt       = pick;
        valid_nxt      = 1'b1;
        tries_nxt      = '0;
        dealt_nxt      = deck_full ? dealt_q : dealt_q + CW'(1);
        remaining_nxt  = remaining - 2'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      used      <= '0;
      cand      <= '0;
      ptr       <= '0;
      tries     <= '0;
      remaining <= '0;
      card_q    <= '0;
      dealt_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      used      <= used_nxt;
      cand      <= cand_nxt;
      ptr       <= ptr_nxt;
      tries     <= tries_nxt;
      remaining <= remaining_nxt;
      card_q    <= card_nxt;
      dealt_q   <= dealt_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end
endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a timeline model schedules each request's expected
// outputs from the draw sequence; a compare process checks them every cycle.
module tb_card_dealer;
  localparam int MT = 4;
  localparam int N  = 16384;

  logic clk = 1'b0;
  logic reset_d;
  card_dealer_if bus();

  card_dealer #(.DECK_SIZE(52), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset_d(reset_d), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Per-cycle expected events; rng_seq[k] is what rng_in carries in cycle k
  bit         ev_valid[N];
  bit         ev_done[N];
  bit         ev_err[N];
  bit         ev_busy[N];
  bit         ev_inc[N];
  bit         ev_clear[N];
  logic [5:0] ev_card[N];
  logic [5:0] rng_seq[N];

  bit used_m[64];
  int m_dealt = 0;
  int idle_at = 0;

  logic [5:0] e_card = 6'd0;
  int         e_dealt = 0;
  bit         e_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 52; i++) if (!used_m[i]) return i;
    return 0;
  endfunction

  // Schedules the whole outcome of an accepted request from the draw values
  task automatic model_step(input int c, input bit nh, input bit req, input int cnt);
    int d, e, end_at, tries, pick;
    bit stop;
    if (nh) begin
      for (int t = c + 1; t < N; t++) begin
        ev_valid[t] = 0; ev_done[t] = 0; ev_err[t] = 0;
        ev_busy[t] = 0;  ev_inc[t] = 0;  ev_clear[t] = 0;
      end
      ev_clear[c+1] = 1;
      for (int i = 0; i < 64; i++) used_m[i] = 0;
      m_dealt = 0;
      idle_at = c + 1;
    end else if (req && c >= idle_at) begin
      if (cnt == 0) begin
        ev_done[c+1] = 1;
        idle_at = c + 2;
      end else begin
        d = c + 1; stop = 0; end_at = c + 1;
        for (int k = 0; k < cnt && !stop; k++) begin
          if (m_dealt == 52) begin
            ev_err[d+1] = 1; end_at = d + 1; stop = 1;
          end else begin
            tries = 0; e = -1; pick = 0;
            while (e < 0) begin
              if (rng_seq[d] < 6'd52 && !used_m[rng_seq[d]]) begin
                pick = int'(rng_seq[d]); e = d + 2;
              end else begin
                tries++;
                if (tries == MT) begin pick = lowest_free(); e = d + 3 + pick; end
                else d += 2;
              end
            end
            ev_valid[e] = 1; ev_card[e] = 6'(pick); ev_inc[e] = 1;
            used_m[pick] = 1; m_dealt++;
            end_at = e + 1; d = e + 1;
          end
        end
        ev_done[end_at] = 1;
        for (int t = c + 1; t <= end_at; t++) ev_busy[t] = 1;
        idle_at = end_at + 1;
      end
    end
  endtask

  // Compare every cycle against the scheduled timeline
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      int t;
      t = cyc;
      if (ev_clear[t]) begin e_dealt = 0; e_err = 0; end
      if (ev_inc[t])   e_dealt++;
      if (ev_valid[t]) e_card = ev_card[t];
      if (ev_err[t])   e_err = 1;
      check("card_valid",  32'(bus.card_valid),  32'(ev_valid[t]));
      check("done",        32'(bus.done),        32'(ev_done[t]));
      check("busy",        32'(bus.busy),        32'(ev_busy[t]));
      check("card",        32'(bus.card),        32'(e_card));
      check("cards_dealt", 32'(bus.cards_dealt), 32'(e_dealt));
      check("err_empty",   32'(bus.err_empty),   32'(e_err));
    end
  end

  task automatic step(input bit nh, input bit req, input int cnt);
    @(posedge clk);
    #1;
    cyc++;
    bus.new_hand   = nh;
    bus.deal_req   = req;
    bus.deal_count = 2'(cnt);
    bus.rng_in     = rng_seq[cyc];
    model_step(cyc, nh, req, cnt);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(0, 0, 0);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < idle_at && n < 2000) begin step(0, 0, 0); n++; end
    if (cyc < idle_at) begin
      errors++;
      $display("FAIL wait_idle timeout at cycle %0d", cyc);
    end
  endtask

  initial begin
    int c, g;
    reset_d = 1'b1;
    bus.new_hand = 0; bus.deal_req = 0; bus.deal_count = 0; bus.rng_in = 0;
    for (int k = 0; k < N; k++) rng_seq[k] = 6'($urandom_range(0, 63));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst card",        32'(bus.card),        32'd0);
    check("rst card_valid",  32'(bus.card_valid),  32'd0);
    check("rst cards_dealt", 32'(bus.cards_dealt), 32'd0);
    check("rst busy",        32'(bus.busy),        32'd0);
    check("rst done",        32'(bus.done),        32'd0);
    check("rst err_empty",   32'(bus.err_empty),   32'd0);
    reset_d = 1'b0;
    chk_en = 1'b1;

    // Two hits: cards 5 and 17
    step(1, 0, 0);
    c = cyc + 1; rng_seq[c+1] = 6'd5; rng_seq[c+4] = 6'd17;
    step(0, 1, 2);
    wait_until(c + 3);
    check("t1 first valid", 32'(bus.card_valid), 32'd1);
    check("t1 first card",  32'(bus.card),       32'd5);
    wait_until(c + 6);
    check("t1 second card", 32'(bus.card),       32'd17);
    wait_until(c + 7);
    check("t1 done",        32'(bus.done),        32'd1);
    check("t1 dealt",       32'(bus.cards_dealt), 32'd2);
    wait_idle();

    // Scan fallback after MT rejects of a used card
    step(1, 0, 0);
    c = cyc + 1; rng_seq[c+1] = 6'd5;
    step(0, 1, 1);
    wait_idle();
    for (int r = 0; r < 2; r++) begin
      c = cyc + 1;
      for (int k = 1; k <= 8; k++) rng_seq[c+k] = 6'd5;
      step(0, 1, 1);
      wait_until(c + 10 + r);
      check("t2 scan valid", 32'(bus.card_valid), 32'd1);
      check("t2 scan card",  32'(bus.card),       32'(r));
      wait_idle();
    end

    // Out-of-range draw rejected, then tries restart from zero
    c = cyc + 1; rng_seq[c+1] = 6'd60; rng_seq[c+3] = 6'd12;
    step(0, 1, 1);
    wait_until(c + 5);
    check("t3 card", 32'(bus.card), 32'd12);
    wait_idle();
    c = cyc + 1;
    rng_seq[c+1] = 6'd12; rng_seq[c+3] = 6'd12; rng_seq[c+5] = 6'd12; rng_seq[c+7] = 6'd13;
    step(0, 1, 1);
    wait_until(c + 9);
    check("t3 tries cleared", 32'(bus.card), 32'd13);
    wait_idle();

    // Exhaust the deck, then request one more
    step(1, 0, 0);
    g = 0;
    while (m_dealt < 52 && g < 40) begin step(0, 1, 3); wait_idle(); g++; end
    c = cyc + 1;
    step(0, 1, 1);
    wait_until(c + 2);
    check("t4 done",      32'(bus.done),        32'd1);
    check("t4 err",       32'(bus.err_empty),   32'd1);
    check("t4 no card",   32'(bus.card_valid),  32'd0);
    check("t4 dealt",     32'(bus.cards_dealt), 32'd52);
    wait_idle();
    c = cyc + 1;
    step(1, 0, 0);
    wait_until(c + 1);
    check("t4 err clear",   32'(bus.err_empty),   32'd0);
    check("t4 dealt clear", 32'(bus.cards_dealt), 32'd0);

    // Abort in CHECK; a deal_req while busy is ignored
    c = cyc + 1;
    step(0, 1, 3);
    step(0, 1, 2);
    step(1, 0, 0);
    wait_until(c + 3);
    check("t5 busy",  32'(bus.busy),        32'd0);
    check("t5 done",  32'(bus.done),        32'd0);
    check("t5 dealt", 32'(bus.cards_dealt), 32'd0);
    repeat (6) step(0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1499) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
    wait_idle();

    // Asynchronous reset while scanning
    step(1, 0, 0);
    c = cyc + 1; rng_seq[c+1] = 6'd7;
    step(0, 1, 1);
    wait_idle();
    c = cyc + 1;
    for (int k = 1; k <= 8; k++) rng_seq[c+k] = 6'd7;
    step(0, 1, 1);
    wait_until(c + 9);
    check("t6 busy before", 32'(bus.busy), 32'd1);
    check("t6 card before", 32'(bus.card), 32'd7);
    chk_en = 1'b0;
    #1 reset_d = 1'b1;
    #1;
    check("t6 card",        32'(bus.card),        32'd0);
    check("t6 card_valid",  32'(bus.card_valid),  32'd0);
    check("t6 cards_dealt", 32'(bus.cards_dealt), 32'd0);
    check("t6 busy",        32'(bus.busy),        32'd0);
    check("t6 done",        32'(bus.done),        32'd0);
    check("t6 err_empty",   32'(bus.err_empty),   32'd0);
    repeat (2) @(posedge clk);
    reset_d = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
